// File: rtl/sid_pkg.sv
// Shared constants, resonance table and FSM encoding for the multi-voice SID filter.
package sid_pkg;

  localparam int W0_K      = 82355;
  localparam int W0_SHIFT  = 12;
  localparam int INT_SHIFT = 19;
  localparam int Q_SHIFT   = 10;
  localparam int OUT_SHIFT = 3;

  // 1/Q in 1.10 fixed point, indexed by the resonance code
  localparam logic [10:0] Q_TABLE [16] = '{
    11'd1448, 11'd1328, 11'd1218, 11'd1117, 11'd1024, 11'd939, 11'd861, 11'd790,
    11'd724,  11'd664,  11'd609,  11'd558,  11'd512,  11'd470, 11'd431, 11'd395
  };

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_MIX, S_BP, S_LP, S_HP, S_VF, S_OUT
  } state_t;

endpackage

// File: rtl/sid_sat_addsub.sv
// Combinational signed add/subtract clamped to the W-bit range, no wrap.
module sid_sat_addsub
  import sid_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);

  logic signed [W:0] r;

  always_comb begin
    r = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    y = r[W-1:0];
    // one guard bit is enough to see overflow of a single add/sub
    if (r[W] != r[W-1]) y = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/sid_filter_mc.sv
// Frame-based SID mixer + Chamberlin SVF on one shared multiplier; NUM_VOICES+8 cycle latency.
// One frame in flight: in_ready only in IDLE, in_valid while busy is dropped.
module sid_filter_mc
  import sid_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int ACC_W      = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [10:0]                   fc,
  input  logic [3:0]                    res,
  input  logic [NUM_VOICES:0]           filt_sel,
  input  logic [3:0]                    mode,
  input  logic [3:0]                    vol,
  input  logic [NUM_VOICES*VOICE_W-1:0] voices,
  input  logic [VOICE_W-1:0]            ext_in,
  input  logic                          ext_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [ACC_W-1:0]       sound,
  output logic                          out_valid
);

  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int XW    = 2 * ACC_W + 2;
  localparam logic signed [XW-1:0] XMAX = {{(XW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [XW-1:0] XMIN = ~XMAX;

  function automatic logic signed [ACC_W-1:0] sat_x(input logic signed [XW-1:0] x);
    if (x > XMAX)      return {1'b0, {(ACC_W-1){1'b1}}};
    else if (x < XMIN) return {1'b1, {(ACC_W-1){1'b0}}};
    else               return x[ACC_W-1:0];
  endfunction

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [10:0]                     fc_q;
  logic [3:0]                      res_q, mode_q, vol_q;
  logic [NUM_VOICES:0]             filt_q;
  logic [NUM_VOICES*VOICE_W-1:0]   voices_q;
  logic [VOICE_W-1:0]              ext_q;
  logic                            ext_en_q;
  logic signed [ACC_W-1:0]         w0, vbp, vlp, vhp, vi, vnf, vf;

  logic signed [ACC_W-1:0]         mul_a, mul_b;
  logic signed [2*ACC_W-1:0]       prod;
  logic signed [VOICE_W-1:0]       src_raw;
  logic signed [ACC_W-1:0]         src_scaled;
  logic                            routed, skip;
  logic signed [ACC_W-1:0]         acc_a, acc_b, acc_y, int_a, int_b, int_y;
  logic                            acc_sub;
  logic signed [XW-1:0]            hp_x, vf_x;

  assign in_ready = (state == S_IDLE);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_W0:  begin mul_a = ACC_W'(W0_K);            mul_b = ACC_W'(fc_q) + ACC_W'(1); end
      S_BP:  begin mul_a = w0;                      mul_b = vhp;                      end
      S_LP:  begin mul_a = w0;                      mul_b = vbp;                      end
      S_HP:  begin mul_a = ACC_W'(Q_TABLE[res_q]);  mul_b = vbp;                      end
      S_OUT: begin mul_a = acc_y;                   mul_b = ACC_W'(vol_q);            end
      default: ;
    endcase
  end

  assign prod = (2*ACC_W)'(mul_a) * (2*ACC_W)'(mul_b);

  always_comb begin
    src_raw = ext_q;
    for (int i = 0; i < NUM_VOICES; i++)
      if (cnt == CNT_W'(i)) src_raw = voices_q[i*VOICE_W +: VOICE_W];
  end

  assign src_scaled = ACC_W'(src_raw) <<< 2;
  assign routed     = filt_q[cnt];
  assign skip       = !routed && mode_q[3] && (cnt == CNT_W'(NUM_VOICES - 1));

  // The mix adder accumulates sources in MIX and forms the final mix in OUT
  always_comb begin
    acc_a   = vnf;
    acc_b   = src_scaled;
    acc_sub = 1'b0;
    if (state == S_MIX) begin
      acc_a = routed ? vi : vnf;
    end else if (state == S_OUT) begin
      acc_b   = ext_en_q ? vf : vi;
      acc_sub = ext_en_q;
    end
  end

  assign int_a = (state == S_LP) ? vlp : vbp;
  assign int_b = ACC_W'(prod >>> INT_SHIFT);

  sid_sat_addsub #(.W(ACC_W)) u_acc (.a(acc_a), .b(acc_b), .sub(acc_sub), .y(acc_y));
  sid_sat_addsub #(.W(ACC_W)) u_int (.a(int_a), .b(int_b), .sub(1'b1),    .y(int_y));

  assign hp_x = XW'(prod >>> Q_SHIFT) - XW'(vlp) - XW'(vi);

  always_comb begin
    vf_x = '0;
    if (mode_q[0]) vf_x = vf_x + XW'(vlp);
    if (mode_q[1]) vf_x = vf_x + XW'(vbp);
    if (mode_q[2]) vf_x = vf_x + XW'(vhp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;  cnt <= '0;      fc_q <= '0;     res_q <= '0;
      mode_q <= '0;     vol_q <= '0;    filt_q <= '0;   voices_q <= '0;
      ext_q <= '0;      ext_en_q <= 1'b0;
      w0 <= '0;  vbp <= '0;  vlp <= '0;  vhp <= '0;  vi <= '0;  vnf <= '0;  vf <= '0;
      sound <= '0;      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          fc_q <= fc;  res_q <= res;  filt_q <= filt_sel;  mode_q <= mode;  vol_q <= vol;
          voices_q <= voices;  ext_q <= ext_in;  ext_en_q <= ext_en;
          vi <= '0;  vnf <= '0;  vf <= '0;  cnt <= '0;
          state <= S_W0;
        end
        S_W0: begin
          w0    <= ACC_W'(prod >> W0_SHIFT);
          state <= S_MIX;
        end
        S_MIX: begin
          if (routed)     vi  <= acc_y;
          else if (!skip) vnf <= acc_y;
          if (cnt == CNT_W'(NUM_VOICES)) state <= S_BP;
          else                           cnt   <= cnt + 1'b1;
        end
        S_BP: begin vbp <= int_y;       state <= S_LP; end
        S_LP: begin vlp <= int_y;       state <= S_HP; end
        S_HP: begin vhp <= sat_x(hp_x); state <= S_VF; end
        S_VF: begin vf  <= sat_x(vf_x); state <= S_OUT; end
        S_OUT: begin
          sound     <= sat_x(XW'(prod >>> OUT_SHIFT));
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_filter_mc.sv
// Directed + randomized bench for sid_filter_mc against a frame-level arithmetic model.
module tb_sid_filter_mc;

  localparam int N  = 3;
  localparam int N8 = 8;
  localparam int VW = 12;
  localparam int AW = 18;
  localparam longint SMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (AW - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [10:0]          fc;
  logic [3:0]           res, mode, vol;
  logic [N:0]           filt_sel;
  logic [N*VW-1:0]      voices;
  logic [VW-1:0]        ext_in;
  logic                 ext_en, in_valid, in_ready, out_valid;
  logic signed [AW-1:0] sound;

  logic [10:0]          fc_8;
  logic [3:0]           res_8, mode_8, vol_8;
  logic [N8:0]          filt_sel_8;
  logic [N8*VW-1:0]     voices_8;
  logic [VW-1:0]        ext_in_8;
  logic                 ext_en_8, in_valid_8, in_ready_8, out_valid_8;
  logic signed [AW-1:0] sound_8;

  sid_filter_mc u_dut (
    .clk(clk), .rst(rst), .fc(fc), .res(res), .filt_sel(filt_sel), .mode(mode), .vol(vol),
    .voices(voices), .ext_in(ext_in), .ext_en(ext_en), .in_valid(in_valid),
    .in_ready(in_ready), .sound(sound), .out_valid(out_valid)
  );

  sid_filter_mc #(.NUM_VOICES(N8)) u_dut8 (
    .clk(clk), .rst(rst), .fc(fc_8), .res(res_8), .filt_sel(filt_sel_8), .mode(mode_8),
    .vol(vol_8), .voices(voices_8), .ext_in(ext_in_8), .ext_en(ext_en_8),
    .in_valid(in_valid_8), .in_ready(in_ready_8), .sound(sound_8), .out_valid(out_valid_8)
  );

  int checks = 0;
  int failures = 0;
  int quiet_bad = 0;
  int qtab [16] = '{1448, 1328, 1218, 1117, 1024, 939, 861, 790,
                    724, 664, 609, 558, 512, 470, 431, 395};

  longint m_bp = 0, m_lp = 0, m_hp = 0;
  int cv [9];
  int cext, cfc, cres, cfilt, cmode, cvol, cen;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint clamp(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  // One frame of the filter computed straight from the arithmetic rules.
  task automatic model_frame(input int n, input int vs [9], input int ext, input int fcv,
                             input int resv, input int filtv, input int modev, input int volv,
                             input int env, inout longint bp, inout longint lp,
                             inout longint hp, output longint snd);
    longint vi = 0, vnf = 0, s, w0, vf, mix;
    for (int i = 0; i <= n; i++) begin
      s = longint'((i == n) ? ext : vs[i]) * 4;
      if (((filtv >> i) & 1) == 1) vi = clamp(vi + s);
      else if (!(i == n - 1 && ((modev >> 3) & 1) == 1)) vnf = clamp(vnf + s);
    end
    w0 = (longint'(82355) * (fcv + 1)) / 4096;
    bp = clamp(bp - ((w0 * hp) >>> 19));
    lp = clamp(lp - ((w0 * bp) >>> 19));
    hp = clamp(((qtab[resv] * bp) >>> 10) - lp - vi);
    vf = 0;
    if ((modev & 1) != 0) vf += lp;
    if ((modev & 2) != 0) vf += bp;
    if ((modev & 4) != 0) vf += hp;
    vf  = clamp(vf);
    mix = clamp((env != 0) ? vnf - vf : vnf + vi);
    snd = clamp((mix * volv) >>> 3);
  endtask

  task automatic drive();
    fc = 11'(cfc); res = 4'(cres); filt_sel = (N+1)'(cfilt); mode = 4'(cmode);
    vol = 4'(cvol); ext_en = 1'(cen); ext_in = VW'(cext);
    for (int i = 0; i < N; i++) voices[i*VW +: VW] = VW'(cv[i]);
  endtask

  task automatic scramble();
    fc = 11'($urandom); res = 4'($urandom); filt_sel = (N+1)'($urandom); mode = 4'($urandom);
    vol = 4'($urandom); voices = (N*VW)'({$urandom, $urandom}); ext_in = VW'($urandom);
    ext_en = 1'($urandom);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 9; i++) cv[i] = int'($urandom_range(4095)) - 2048;
    cext = int'($urandom_range(4095)) - 2048;
    cfc = int'($urandom_range(2047)); cres = int'($urandom_range(15));
    cfilt = int'($urandom_range(15)); cmode = int'($urandom_range(15));
    cvol = int'($urandom_range(15)); cen = int'($urandom_range(1));
  endtask

  task automatic defaults_frame();
    for (int i = 0; i < 9; i++) cv[i] = 0;
    cv[0] = 256; cext = 0; cfc = 0; cres = 0; cfilt = 0; cmode = 0; cvol = 15; cen = 1;
  endtask

  // Accept one frame, then perturb the inputs while it is in flight.
  task automatic frame1(input string tag, input bit quiet);
    longint e;
    int lat;
    drive();
    model_frame(N, cv, cext, cfc, cres, cfilt, cmode, cvol, cen, m_bp, m_lp, m_hp, e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (quiet) begin
      if (!out_valid || longint'(sound) != e) quiet_bad++;
    end else begin
      check({tag, "_latency"}, lat, N + 8);
      check({tag, "_sound"}, longint'(sound), e);
    end
  endtask

  task automatic frame8(input string tag, input int val, input longint exp);
    int lat;
    for (int i = 0; i < N8; i++) voices_8[i*VW +: VW] = VW'(val);
    ext_in_8 = VW'(val); filt_sel_8 = '0; mode_8 = 4'd0; vol_8 = 4'd15; ext_en_8 = 1'b1;
    fc_8 = 11'd0; res_8 = 4'd0;
    in_valid_8 = 1'b1;
    tick();
    in_valid_8 = 1'b0;
    lat = 1;
    while (!out_valid_8 && lat < 60) begin tick(); lat++; end
    check({tag, "_latency"}, lat, N8 + 8);
    check({tag, "_sound"}, longint'(sound_8), exp);
  endtask

  initial begin
    longint e, got, dev;
    int nov, glat, seen, cyc, prev, flips, sgn, psgn;

    rst = 1'b1; in_valid = 1'b0; in_valid_8 = 1'b0;
    defaults_frame(); drive();
    fc_8 = '0; res_8 = '0; mode_8 = '0; vol_8 = '0; filt_sel_8 = '0; voices_8 = '0;
    ext_in_8 = '0; ext_en_8 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_sound", longint'(sound), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready_n8", in_ready_8, 1);
    nov = 0;
    repeat (50) begin tick(); if (out_valid || out_valid_8) nov++; end
    check("idle_no_out_valid", nov, 0);

    defaults_frame();
    frame1("defaults", 0);
    check("defaults_1920", longint'(sound), 1920);

    for (int k = 0; k < 25; k++) begin rand_frame(); frame1("rand", 0); end

    // in_valid held high: one frame per NUM_VOICES+8 cycles
    rand_frame(); drive(); in_valid = 1'b1;
    seen = 0; cyc = 0; prev = 0;
    while (seen < 4 && cyc < 100) begin
      tick(); cyc++;
      if (out_valid) begin
        model_frame(N, cv, cext, cfc, cres, cfilt, cmode, cvol, cen, m_bp, m_lp, m_hp, e);
        check("cont_sound", longint'(sound), e);
        check("cont_period", cyc - prev, N + 8);
        prev = cyc; seen++;
      end
    end
    in_valid = 1'b0;
    check("cont_frames", seen, 4);
    nov = 0;
    repeat (30) begin tick(); if (out_valid) nov++; end
    check("cont_no_extra", nov, 0);

    // in_valid pulses while busy are dropped
    rand_frame(); drive();
    model_frame(N, cv, cext, cfc, cres, cfilt, cmode, cvol, cen, m_bp, m_lp, m_hp, e);
    in_valid = 1'b1; tick();
    nov = 0; got = 0; glat = 0;
    for (int c = 1; c <= 30; c++) begin
      in_valid = (c == 3 || c == 6 || c == 9);
      if (in_valid) voices = (N*VW)'({$urandom, $urandom});
      tick();
      if (out_valid) begin nov++; got = longint'(sound); glat = c + 1; end
    end
    in_valid = 1'b0;
    check("busy_frames", nov, 1);
    check("busy_latency", glat, N + 8);
    check("busy_sound", got, e);

    // vol = 0 mutes the output but the filter state keeps moving
    rand_frame(); cvol = 0; cfilt = 15; cmode = 7;
    frame1("vol0", 0);
    check("vol0_zero", longint'(sound), 0);
    rand_frame(); cvol = 15; frame1("after_vol0", 0);

    // reset mid-frame aborts with no output
    rand_frame(); drive(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    m_bp = 0; m_lp = 0; m_hp = 0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_sound", longint'(sound), 0);
    nov = out_valid ? 1 : 0;
    repeat (20) begin tick(); if (out_valid) nov++; end
    check("midrst_no_out_valid", nov, 0);
    defaults_frame();
    frame1("post_rst", 0);
    check("post_rst_1920", longint'(sound), 1920);

    // low-pass step response settles to the routed input level
    for (int i = 0; i < 9; i++) cv[i] = 0;
    cv[0] = 2047; cext = 0; cfc = 2047; cres = 0; cfilt = 1; cmode = 1; cvol = 15; cen = 1;
    flips = 0; psgn = 0;
    for (int k = 0; k < 2000; k++) begin
      frame1("lp", 1);
      if (k >= 1000) begin
        sgn = (sound < 0) ? -1 : 1;
        if (k > 1000 && sgn != psgn) flips++;
        psgn = sgn;
      end
    end
    check("lp_model_mismatches", quiet_bad, 0);
    check("lp_sign_flips", flips, 0);
    dev = longint'(sound) - 15352;
    check("lp_settle_band", (dev <= 153 && dev >= -153) ? 1 : 0, 1);

    frame8("n8_pos_sat", 2047, 131071);
    frame8("n8_neg_sat", -2048, -131072);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
